// File: rtl/irq_event_gen.sv
// Purpose : per-channel event qualifier/coalescer producing sticky level interrupts and overflow flags.
// Latency : qualifying event in cycle n -> irq_o in cycle n+1 (n+3 with IRQ_EVT_SYNC_EN defined).
// Backpr. : clear port is valid/ready; ready drops for the one cycle after every accepted clear.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   evt_i                 raw event inputs (may be asynchronous only when IRQ_EVT_SYNC_EN is defined)
//   edge_mode_i           per channel: 1 = rising-edge qualified, 0 = level qualified
//   thresh_i              global coalescing threshold (0 behaves as 1)
//   clr_valid_i/clr_idx_i clear request; clr_ready_o handshake ready
//   clr_err_o             one-cycle pulse after an accepted clear whose index is out of range
//   irq_o, ovf_o, cnt_o   pending bits, sticky overflow bits, packed counters (channel 0 in LSBs)
// Optional macro: IRQ_EVT_SYNC_EN inserts a 2-flop synchroniser on evt_i.
module irq_event_gen #(
    parameter int N_EVT = 8,
    parameter int CNT_W = 8,
    parameter int IDX_W = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_EVT-1:0]       evt_i,
    input  logic [N_EVT-1:0]       edge_mode_i,
    input  logic [CNT_W-1:0]       thresh_i,
    input  logic                   clr_valid_i,
    input  logic [IDX_W-1:0]       clr_idx_i,
    output logic                   clr_ready_o,
    output logic                   clr_err_o,
    output logic [N_EVT-1:0]       irq_o,
    output logic [N_EVT-1:0]       ovf_o,
    output logic [N_EVT*CNT_W-1:0] cnt_o
);

    localparam logic [IDX_W:0] N_EVT_L = (IDX_W+1)'(N_EVT);

    logic [N_EVT-1:0]            e;
    logic [N_EVT-1:0]            e_q, e_d;
    logic [N_EVT-1:0]            qual;
    logic [N_EVT-1:0]            pend_q, pend_d;
    logic [N_EVT-1:0]            ovf_q, ovf_d;
    logic [N_EVT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        clr_ready_q, clr_ready_d;
    logic                        clr_err_q, clr_err_d;

    logic [CNT_W-1:0]            thr_eff;
    logic                        clr_fire;
    logic                        clr_bad;

    // Per-channel scratch values, rewritten every loop iteration.
    logic                        clr_hit;
    logic [CNT_W-1:0]            cnt_base;
    logic                        pend_base;
    logic                        ovf_base;
    logic [CNT_W:0]              cnt_inc;

`ifdef IRQ_EVT_SYNC_EN
    logic [N_EVT-1:0] sync1_q, sync1_d;
    logic [N_EVT-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = evt_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign e = sync2_q;
`else
    assign e = evt_i;
`endif

    assign thr_eff  = (thresh_i == '0) ? CNT_W'(1) : thresh_i;
    assign clr_fire = clr_valid_i & clr_ready_q;
    assign clr_bad  = ({1'b0, clr_idx_i} >= N_EVT_L);

    // Edge history tracks e every cycle regardless of mode, so switching
    // a channel to edge mode never sees a stale history bit.
    assign qual = (edge_mode_i & e & ~e_q) | (~edge_mode_i & e);

    always_comb begin
        e_d         = e;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        clr_ready_d = ~clr_fire;
        clr_err_d   = clr_fire & clr_bad;
        clr_hit     = 1'b0;
        cnt_base    = '0;
        pend_base   = 1'b0;
        ovf_base    = 1'b0;
        cnt_inc     = '0;

        for (int i = 0; i < N_EVT; i++) begin
            // A clear is applied first so that a same-cycle event is counted
            // against a fresh channel rather than being lost.
            clr_hit   = clr_fire && ({1'b0, clr_idx_i} == (IDX_W+1)'(i));
            cnt_base  = clr_hit ? '0   : cnt_q[i];
            pend_base = clr_hit ? 1'b0 : pend_q[i];
            ovf_base  = clr_hit ? 1'b0 : ovf_q[i];
            cnt_inc   = {1'b0, cnt_base} + (CNT_W+1)'(1);

            cnt_d[i]  = cnt_base;
            pend_d[i] = pend_base;
            ovf_d[i]  = ovf_base;

            if (qual[i]) begin
                ovf_d[i] = ovf_base | pend_base;
                // Clamp to thr_eff; also covers a threshold lowered below the count.
                if (cnt_inc >= {1'b0, thr_eff}) begin
                    cnt_d[i]  = thr_eff;
                    pend_d[i] = 1'b1;
                end else begin
                    cnt_d[i]  = cnt_inc[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_q         <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            cnt_q       <= '0;
            clr_ready_q <= 1'b0;
            clr_err_q   <= 1'b0;
        end else begin
            e_q         <= e_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            clr_ready_q <= clr_ready_d;
            clr_err_q   <= clr_err_d;
        end
    end

    assign irq_o       = pend_q;
    assign ovf_o       = ovf_q;
    assign cnt_o       = cnt_q;
    assign clr_ready_o = clr_ready_q;
    assign clr_err_o   = clr_err_q;

endmodule

// File: tb/tb_irq_event_gen.sv
// Purpose : directed self-checking bench for irq_event_gen (N_EVT=8, CNT_W=8, IDX_W=4).
// Latency : inputs driven 1ns after a rising edge, outputs checked 1ns after the following edge.
// Backpr. : clear requests are held by the bench until the expected accept cycle.
module tb_irq_event_gen;

    logic        clk;
    logic        rst_n;
    logic [7:0]  evt;
    logic [7:0]  edge_mode;
    logic [7:0]  thresh;
    logic        clr_valid;
    logic [3:0]  clr_idx;
    logic        clr_ready;
    logic        clr_err;
    logic [7:0]  irq;
    logic [7:0]  ovf;
    logic [63:0] cnt;

    int n_chk  = 0;
    int n_pass = 0;

    irq_event_gen #(
        .N_EVT (8),
        .CNT_W (8),
        .IDX_W (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .evt_i       (evt),
        .edge_mode_i (edge_mode),
        .thresh_i    (thresh),
        .clr_valid_i (clr_valid),
        .clr_idx_i   (clr_idx),
        .clr_ready_o (clr_ready),
        .clr_err_o   (clr_err),
        .irq_o       (irq),
        .ovf_o       (ovf),
        .cnt_o       (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt_of(input int ch);
        return cnt[ch*8 +: 8];
    endfunction

    initial begin
        rst_n     = 1'b0;
        evt       = '0;
        edge_mode = 8'hFF;
        thresh    = 8'd1;
        clr_valid = 1'b0;
        clr_idx   = '0;

        // Reset state
        #2;
        chk("rst_irq",   64'(irq), 64'h0);
        chk("rst_ovf",   64'(ovf), 64'h0);
        chk("rst_cnt",   cnt,      64'h0);
        chk("rst_ready", 64'(clr_ready), 64'h0);
        chk("rst_err",   64'(clr_err),   64'h0);
        #20;
        rst_n = 1'b1;
        step();
        chk("rel_ready", 64'(clr_ready), 64'h1);

        // Edge mode, threshold 1, ch0 held high 5 cycles
        evt[0] = 1'b1;
        step();
        chk("e1_irq_lat", 64'(irq[0]), 64'h1);
        for (int k = 0; k < 4; k++) step();
        evt[0] = 1'b0;
        chk("e1_irq",  64'(irq[0]),   64'h1);
        chk("e1_cnt",  64'(cnt_of(0)), 64'h1);
        chk("e1_ovf",  64'(ovf[0]),   64'h0);

        // Coalescing, threshold 3, three pulses on ch2 spaced 4 cycles
        thresh = 8'd3;
        for (int p = 1; p <= 3; p++) begin
            evt[2] = 1'b1;
            step();
            evt[2] = 1'b0;
            chk("c3_irq", 64'(irq[2]),    (p == 3) ? 64'h1 : 64'h0);
            chk("c3_cnt", 64'(cnt_of(2)), 64'(p));
            for (int k = 0; k < 3; k++) step();
        end
        chk("c3_ovf", 64'(ovf[2]), 64'h0);

        // Level mode, threshold 0 (acts as 1), ch1 high 4 cycles
        edge_mode = 8'hFD;
        thresh    = 8'd0;
        evt[1]    = 1'b1;
        step();
        chk("lv_irq",  64'(irq[1]), 64'h1);
        chk("lv_ovf0", 64'(ovf[1]), 64'h0);
        step();
        chk("lv_ovf1", 64'(ovf[1]), 64'h1);
        step();
        step();
        evt[1] = 1'b0;
        chk("lv_cnt", 64'(cnt_of(1)), 64'h1);
        edge_mode = 8'hFF;
        thresh    = 8'd1;

        // Build ch3 pending + overflow with two edges
        evt[3] = 1'b1; step();
        evt[3] = 1'b0; step();
        evt[3] = 1'b1; step();
        evt[3] = 1'b0;
        chk("c3pre_ovf", 64'(ovf[3]), 64'h1);
        step();
        chk("cl_ready_pre", 64'(clr_ready), 64'h1);

        // Clear and new edge on ch3 in the same cycle
        evt[3]    = 1'b1;
        clr_valid = 1'b1;
        clr_idx   = 4'd3;
        step();
        clr_valid = 1'b0;
        evt[3]    = 1'b0;
        chk("ce_irq",   64'(irq[3]),     64'h1);
        chk("ce_ovf",   64'(ovf[3]),     64'h0);
        chk("ce_cnt",   64'(cnt_of(3)),  64'h1);
        chk("ce_ready", 64'(clr_ready),  64'h0);
        step();
        chk("ce_ready_back", 64'(clr_ready), 64'h1);

        // Invalid index clear
        clr_valid = 1'b1;
        clr_idx   = 4'd9;
        step();
        clr_valid = 1'b0;
        chk("bad_err",   64'(clr_err), 64'h1);
        chk("bad_irq",   64'(irq),     64'h0F);
        chk("bad_ovf",   64'(ovf),     64'h02);
        chk("bad_ready", 64'(clr_ready), 64'h0);
        step();
        chk("bad_err_end", 64'(clr_err),   64'h0);
        chk("bad_ready1",  64'(clr_ready), 64'h1);

        // Valid held 3 cycles on ch2: accepts in cycles 1 and 3 only
        clr_valid = 1'b1;
        clr_idx   = 4'd2;
        step();
        chk("bb_irq",    64'(irq),       64'h0B);
        chk("bb_ready1", 64'(clr_ready), 64'h0);
        step();
        chk("bb_ready2", 64'(clr_ready), 64'h1);
        step();
        chk("bb_ready3", 64'(clr_ready), 64'h0);
        chk("bb_err",    64'(clr_err),   64'h0);
        chk("bb_cnt2",   64'(cnt_of(2)), 64'h0);
        clr_valid = 1'b0;
        step();
        chk("bb_ready4", 64'(clr_ready), 64'h1);

        // Reset mid-operation with a clear waiting behind ready=0
        clr_valid = 1'b1;
        clr_idx   = 4'd3;
        step();
        chk("mr_pre_irq", 64'(irq), 64'h03);
        clr_idx = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_irq",   64'(irq),       64'h0);
        chk("mr_ovf",   64'(ovf),       64'h0);
        chk("mr_cnt",   cnt,            64'h0);
        chk("mr_ready", 64'(clr_ready), 64'h0);
        clr_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("mr_ready_in_rst", 64'(clr_ready), 64'h0);
        rst_n = 1'b1;
        step();
        chk("mr_ready_rel", 64'(clr_ready), 64'h1);
        chk("mr_irq_rel",   64'(irq),       64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_event_gen.md
Name: irq_event_gen

Overview:
- Peripheral-side interrupt source block. It converts raw event signals into sticky level interrupts that feed the `irq_i` vector of the interrupt controller.
- Per channel: edge or level qualification, event coalescing against a threshold, a sticky pending bit and a sticky overflow flag.
- Software or a local FSM clears a channel through a valid/ready clear port once the interrupt has been serviced.

Parameters:
- N_EVT, 8, number of event channels (1..32).
- CNT_W, 8, width of the per-channel coalescing counter and of the threshold.
- IDX_W, $clog2(N_EVT) (minimum 1), width of the clear index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- evt_i  in  N_EVT  raw event inputs, synchronous to clk_i unless IRQ_EVT_SYNC_EN
- edge_mode_i  in  N_EVT  per channel: 1 = rising-edge qualified, 0 = level qualified
- thresh_i  in  CNT_W  global coalescing threshold; 0 is treated as 1
- clr_valid_i  in  1  clear request valid
- clr_idx_i  in  IDX_W  channel to clear
- clr_ready_o  out  1  clear handshake ready
- clr_err_o  out  1  one-cycle pulse: accepted clear had clr_idx_i >= N_EVT
- irq_o  out  N_EVT  level interrupt per channel (pending bits), to irq_ctrl irq_i
- ovf_o  out  N_EVT  sticky overflow per channel
- cnt_o  out  N_EVT*CNT_W  packed per-channel event counts, channel 0 in LSBs

Behaviour:
- Reset (async, rst_ni low): irq_o=0, ovf_o=0, all counters=0, edge history=0, clr_err_o=0, clr_ready_o=0. Synchroniser flops (if present) are also reset to 0.
- Release: clr_ready_o=1 from the first clk edge after rst_ni deasserts.
- Qualification, per channel i, computed on the effective event e[i] (evt_i, or its synchronised copy):
  - edge mode: q[i] = e[i] & ~e_q[i], where e_q is e registered each cycle.
  - level mode: q[i] = e[i], so each high cycle counts as one event.
  - e_q[i] updates every cycle regardless of mode.
- Threshold: thr_eff = (thresh_i==0) ? 1 : thresh_i. thresh_i is sampled every cycle; no latching.
- Counting: on q[i], cnt[i] <= sat(cnt[i]+1), saturating at thr_eff and never exceeding it.
  - If cnt[i]+1 >= thr_eff, pending[i] <= 1.
  - If q[i] and pending[i] was already 1, ovf[i] <= 1.
- Threshold lowered below a current count: the next qualifying event sets pending; the counter clamps to thr_eff.
- Latency: qualifying evt_i in cycle n gives irq_o high in cycle n+1 (registered); n+3 with IRQ_EVT_SYNC_EN.
- Clear handshake:
  - Accepted on clr_valid_i & clr_ready_o.
  - clr_ready_o deasserts for exactly the cycle after an accept, so at most one clear every 2 cycles.
  - The requester holds clr_valid_i/clr_idx_i until accepted.
  - Accepted, valid index j: the next cycle has pending[j]=0, ovf[j]=0, cnt[j]=0.
  - Accepted, index >= N_EVT: no state change; clr_err_o pulses high for the next cycle.
- Simultaneous clear and qualifying event on the same channel, same cycle:
  - Clear applies first, then the event counts: cnt <= 1, pending <= (1 >= thr_eff), ovf <= 0.
  - No event is lost.
- Channel independence: a clear affects only channel j; other channels keep counting in the same cycle.
- Reset mid-operation: all state drops immediately (async), including a clear in flight. After reset the requester must re-present any clear.
- All outputs come directly from flops; no combinational input-to-output path.

Optional Feature:
- IRQ_EVT_SYNC_EN defined:
  - evt_i passes through a 2-flop synchroniser per channel before qualification, so evt_i may be asynchronous.
  - Event-to-irq latency is 3 cycles.
  - Synchroniser flops reset to 0.
- IRQ_EVT_SYNC_EN undefined:
  - evt_i is used directly and must be synchronous to clk_i.
  - Latency is 1 cycle.

Test Plan:
- Edge mode, thresh_i=1: evt_i[0] held high 5 cycles -> irq_o[0] rises 1 cycle after evt rise; cnt[0]=1; ovf_o[0]=0 (only one edge).
- Coalescing, thresh_i=3, edge mode: three 1-cycle pulses on ch2 spaced 4 cycles apart -> irq_o[2] stays 0 after pulses 1 and 2, rises 1 cycle after pulse 3; cnt[2]=3.
- Level mode, thresh_i=0: evt_i[1] high 4 cycles -> irq_o[1]=1 after cycle 1; ovf_o[1]=1 from the 2nd event on; cnt[1]=1 (saturated at thr_eff=1).
- Clear plus event together, thresh_i=1, ch3 pending and ovf=1: clr_idx_i=3 accepted in the same cycle as a new ch3 edge -> next cycle irq_o[3]=1, ovf_o[3]=0, cnt[3]=1; clr_ready_o low for that one cycle.
- Invalid clear, N_EVT=8 with IDX_W widened to 4 in the bench: clr_idx_i=9 -> clr_err_o pulses 1 cycle; irq_o and ovf_o unchanged. Back-to-back valid held 3 cycles -> only accepts 2 cycles apart.
- Reset mid-operation: ch0 pending, a clear request waiting, rst_ni pulsed low mid-cycle -> irq_o, ovf_o and cnt_o go 0 immediately; clr_ready_o=0 during reset and 1 on the first edge after release.
